// File: rtl/lmsm_sequencer.sv
// ============================================================================
// lmsm_sequencer : LM/SM micro-sequencer; one register micro-op per mask bit.
// Optional: LMSM_PERF_EN enables the saturating issued micro-op counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lmsm_sequencer #(
  parameter logic [3:0] LM_OPCODE = 4'b0110,
  parameter logic [3:0] SM_OPCODE = 4'b0111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_id_valid,
  input  logic [15:0] if_id_instr,
  input  logic        stall_in,
  output logic        uop_valid,
  output logic        uop_store,
  output logic [2:0]  uop_base_reg,
  output logic [2:0]  uop_data_reg,
  output logic [15:0] uop_offset,
  output logic        uop_last,
  output logic        seq_stall,
  output logic        seq_busy,
  output logic        lmsm_nop,
  output logic [15:0] perf_uop_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [2:0]  off_q, off_d;
  logic        store_q, store_d;
  logic [2:0]  base_q, base_d;

  logic [3:0]  w_opcode;
  logic        w_is_sm;
  logic        w_is_lmsm;
  logic [7:0]  w_mask;
  logic [7:0]  w_eff;
  logic [7:0]  w_eff_clr;
  logic [2:0]  w_low_idx;
  logic        w_one_hot;
  logic        w_accept;
  logic        w_unused_instr8;

  assign w_opcode        = if_id_instr[15:12];
  assign w_mask          = if_id_instr[7:0];
  assign w_unused_instr8 = if_id_instr[8];
  assign w_is_sm         = (w_opcode == SM_OPCODE);
  assign w_is_lmsm       = if_id_valid && ((w_opcode == LM_OPCODE) || w_is_sm);

  assign w_eff     = (state_q == SEQ) ? rem_q : (w_is_lmsm ? w_mask : 8'h00);
  assign w_eff_clr = w_eff & (w_eff - 8'd1);
  assign w_one_hot = (w_eff != 8'h00) && (w_eff_clr == 8'h00);

  always_comb begin
    w_low_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_eff[k]) w_low_idx = 3'(k);
    end
  end

  assign uop_valid    = (w_eff != 8'h00) && !flush;
  assign uop_last     = uop_valid && w_one_hot;
  assign uop_data_reg = w_low_idx;
  assign uop_offset   = {13'b0, off_q};
  assign uop_store    = (state_q == SEQ) ? store_q : (w_is_lmsm && w_is_sm);
  assign uop_base_reg = (state_q == SEQ) ? base_q
                      : (w_is_lmsm ? if_id_instr[11:9] : 3'd0);
  assign seq_stall    = uop_valid && !(uop_last && !stall_in);
  assign seq_busy     = (state_q == SEQ);
  assign lmsm_nop     = w_is_lmsm && (state_q == IDLE) && (w_mask == 8'h00) && !flush;
  assign w_accept     = uop_valid && !stall_in;

  // Flush outranks accept; a held (stalled) micro-op leaves all state untouched.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    off_d   = off_q;
    store_d = store_q;
    base_d  = base_q;
    if (flush) begin
      state_d = IDLE;
      rem_d   = 8'h00;
      off_d   = 3'd0;
    end else if (w_accept) begin
      rem_d = w_eff_clr;
      if (state_q == IDLE) begin
        store_d = w_is_sm;
        base_d  = if_id_instr[11:9];
      end
      if (w_eff_clr != 8'h00) begin
        state_d = SEQ;
        off_d   = off_q + 3'd1;
      end else begin
        state_d = IDLE;
        off_d   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= 8'h00;
      off_q   <= 3'd0;
      store_q <= 1'b0;
      base_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      off_q   <= off_d;
      store_q <= store_d;
      base_q  <= base_d;
    end
  end

`ifdef LMSM_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 16'h0000;
    end else if (w_accept && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_uop_cnt = perf_q;
`else
  assign perf_uop_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
// ============================================================================
// tb_lmsm_sequencer : directed self-checking bench for lmsm_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lmsm_sequencer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic        stall_in;
  logic        uop_valid;
  logic        uop_store;
  logic [2:0]  uop_base_reg;
  logic [2:0]  uop_data_reg;
  logic [15:0] uop_offset;
  logic        uop_last;
  logic        seq_stall;
  logic        seq_busy;
  logic        lmsm_nop;
  logic [15:0] perf_uop_cnt;

  int n_chk;
  int n_fail;

  lmsm_sequencer u_dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .stall_in     (stall_in),
    .uop_valid    (uop_valid),
    .uop_store    (uop_store),
    .uop_base_reg (uop_base_reg),
    .uop_data_reg (uop_data_reg),
    .uop_offset   (uop_offset),
    .uop_last     (uop_last),
    .seq_stall    (seq_stall),
    .seq_busy     (seq_busy),
    .lmsm_nop     (lmsm_nop),
    .perf_uop_cnt (perf_uop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled 1 time unit later, well away from either edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic st, input logic fl);
    if_id_valid = v;
    if_id_instr = instr;
    stall_in    = st;
    flush       = fl;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 32'(uop_valid),    32'd0);
    check({tag, ".store"}, 32'(uop_store),    32'd0);
    check({tag, ".base"},  32'(uop_base_reg), 32'd0);
    check({tag, ".data"},  32'(uop_data_reg), 32'd0);
    check({tag, ".off"},   32'(uop_offset),   32'd0);
    check({tag, ".last"},  32'(uop_last),     32'd0);
    check({tag, ".stall"}, 32'(seq_stall),    32'd0);
    check({tag, ".busy"},  32'(seq_busy),     32'd0);
    check({tag, ".nop"},   32'(lmsm_nop),     32'd0);
    check({tag, ".perf"},  32'(perf_uop_cnt), 32'd0);
  endtask

  task automatic check_perf(input string tag, input int exp);
`ifdef LMSM_PERF_EN
    check(tag, 32'(perf_uop_cnt), 32'(exp));
`else
    check(tag, 32'(perf_uop_cnt), 32'd0);
    if (exp < 0) $display("note: negative perf expectation %0d", exp);
`endif
  endtask

  // Stall scenario: R3 is presented for cycles 3,4,5 with stall_in on 3 and 4.
  logic [2:0] stall_data [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic       stall_in_v [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    check_all_zero("reset");

    // Non-LM/SM instruction leaves the decoder in charge.
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    check("other.valid", 32'(uop_valid), 32'd0);
    check("other.stall", 32'(seq_stall), 32'd0);
    check("other.nop",   32'(lmsm_nop),  32'd0);
    check("other.last",  32'(uop_last),  32'd0);

    // LM R2, mask 0x05.
    next_cycle();
    drive(1'b1, 16'h6405, 1'b0, 1'b0);
    check("lm.c0.valid", 32'(uop_valid),    32'd1);
    check("lm.c0.data",  32'(uop_data_reg), 32'd0);
    check("lm.c0.base",  32'(uop_base_reg), 32'd2);
    check("lm.c0.off",   32'(uop_offset),   32'd0);
    check("lm.c0.store", 32'(uop_store),    32'd0);
    check("lm.c0.stall", 32'(seq_stall),    32'd1);
    check("lm.c0.last",  32'(uop_last),     32'd0);
    check("lm.c0.busy",  32'(seq_busy),     32'd0);
    next_cycle();
    #1;
    check("lm.c1.valid", 32'(uop_valid),    32'd1);
    check("lm.c1.data",  32'(uop_data_reg), 32'd2);
    check("lm.c1.base",  32'(uop_base_reg), 32'd2);
    check("lm.c1.off",   32'(uop_offset),   32'd1);
    check("lm.c1.last",  32'(uop_last),     32'd1);
    check("lm.c1.stall", 32'(seq_stall),    32'd0);
    check("lm.c1.busy",  32'(seq_busy),     32'd1);
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    check("lm.c2.busy",  32'(seq_busy),  32'd0);
    check("lm.c2.valid", 32'(uop_valid), 32'd0);
    check_perf("lm.perf", 2);

    // SM R7, full mask.
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      drive(1'b1, 16'h7EFF, 1'b0, 1'b0);
      check($sformatf("sm.%0d.valid", i), 32'(uop_valid),    32'd1);
      check($sformatf("sm.%0d.data", i),  32'(uop_data_reg), 32'(i));
      check($sformatf("sm.%0d.off", i),   32'(uop_offset),   32'(i));
      check($sformatf("sm.%0d.store", i), 32'(uop_store),    32'd1);
      check($sformatf("sm.%0d.base", i),  32'(uop_base_reg), 32'd7);
      check($sformatf("sm.%0d.last", i),  32'(uop_last),     32'(i == 7));
      check($sformatf("sm.%0d.stall", i), 32'(seq_stall),    32'(i != 7));
      check($sformatf("sm.%0d.busy", i),  32'(seq_busy),     32'(i != 0));
    end
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    check("sm.end.busy", 32'(seq_busy), 32'd0);
    check_perf("sm.perf", 10);

    // SM full mask with a two-cycle downstream stall on R3.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(1'b1, 16'h7EFF, stall_in_v[i], 1'b0);
      check($sformatf("stl.%0d.valid", i), 32'(uop_valid),    32'd1);
      check($sformatf("stl.%0d.data", i),  32'(uop_data_reg), 32'(stall_data[i]));
      check($sformatf("stl.%0d.off", i),   32'(uop_offset),   32'(stall_data[i]));
      check($sformatf("stl.%0d.stall", i), 32'(seq_stall),    32'(i != 9));
      check($sformatf("stl.%0d.last", i),  32'(uop_last),     32'(i == 9));
    end
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    check("stl.end.busy", 32'(seq_busy), 32'd0);
    check_perf("stl.perf", 18);

    // Empty mask becomes a bubble.
    next_cycle();
    drive(1'b1, 16'h6200, 1'b0, 1'b0);
    check("nop.nop",   32'(lmsm_nop),  32'd1);
    check("nop.valid", 32'(uop_valid), 32'd0);
    check("nop.stall", 32'(seq_stall), 32'd0);
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    check("nop.busy", 32'(seq_busy), 32'd0);
    check("nop.nop2", 32'(lmsm_nop), 32'd0);

    // Flush while R2 of 0x7EFF is being issued.
    next_cycle();
    drive(1'b1, 16'h7EFF, 1'b0, 1'b0);
    next_cycle();
    check("fl.r1.data", 32'(uop_data_reg), 32'd1);
    next_cycle();
    drive(1'b1, 16'h7EFF, 1'b0, 1'b1);
    check("fl.r2.data",  32'(uop_data_reg), 32'd2);
    check("fl.r2.valid", 32'(uop_valid),    32'd0);
    check("fl.r2.stall", 32'(seq_stall),    32'd0);
    check("fl.r2.nop",   32'(lmsm_nop),     32'd0);
    next_cycle();
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    check("fl.post.busy",  32'(seq_busy),  32'd0);
    check("fl.post.valid", 32'(uop_valid), 32'd0);
    check("fl.post.stall", 32'(seq_stall), 32'd0);
    check_perf("fl.perf", 20);

    // Reset during R5 of 0x7EFF.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(1'b1, 16'h7EFF, 1'b0, 1'b0);
      check($sformatf("rst.%0d.data", i), 32'(uop_data_reg), 32'(i));
    end
    check_perf("rst.perf.before", 25);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    check_all_zero("rst.after");
    next_cycle();
    #1;
    check_all_zero("rst.idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
Micro-sequencer for the IITB-RISC load-multiple (LM) and store-multiple (SM) instructions. It sits beside the decode stage and watches the IF/ID instruction. For each set bit of an LM/SM register mask it issues one single-register micro-op, overriding the normal decoder outputs. It holds IF/ID and fetch until the last micro-op has been accepted.

Parameters:
LM_OPCODE, 4'b0110, opcode in if_id_instr[15:12] that identifies LM
SM_OPCODE, 4'b0111, opcode in if_id_instr[15:12] that identifies SM

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous kill from branch/jump resolution
if_id_valid  input  1  IF/ID register holds a valid instruction
if_id_instr  input  16  IF/ID instruction
stall_in  input  1  downstream (ID/RR) hold; micro-op not accepted this cycle
uop_valid  output  1  micro-op present; decode outputs must be replaced by it
uop_store  output  1  1 = SM (memory write), 0 = LM (memory read, register write)
uop_base_reg  output  3  RA, the address base register
uop_data_reg  output  3  register loaded or stored by this micro-op
uop_offset  output  16  zero-extended word offset added to RA (0..7)
uop_last  output  1  final micro-op of the instruction
seq_stall  output  1  hold PC and IF/ID
seq_busy  output  1  state == SEQ
lmsm_nop  output  1  LM/SM with empty mask; treat as bubble
perf_uop_cnt  output  16  issued micro-op count (see Optional Feature)

Behaviour:
- Decode fields: opcode = instr[15:12]; RA = instr[11:9]; mask = instr[7:0]; instr[8] ignored.
- Mask mapping: bit k selects Rk. Registers are issued in ascending order, R0 first.
- State registers: state {IDLE, SEQ}, rem[7:0], off[2:0], latched store flag and latched base register.
- Effective mask:
  - SEQ: eff = rem.
  - IDLE: eff = mask when if_id_valid and opcode is LM or SM; otherwise 0.
- Micro-op outputs are combinational from eff and the state registers. The first micro-op therefore appears in the same cycle the LM/SM occupies IF/ID (zero latency).
  - uop_valid = (eff != 0) & ~flush.
  - uop_data_reg = index of the lowest set bit of eff.
  - uop_offset = {13'b0, off}.
  - uop_store and uop_base_reg come from the instruction in IDLE and from the latched values in SEQ.
  - uop_last = uop_valid & (eff has exactly one bit set).
- Accept: uop_valid & ~stall_in. On accept:
  - rem <= eff with its lowest set bit cleared.
  - off <= off + 1.
  - In IDLE, also latch store flag and RA.
  - Next state is SEQ if the new rem != 0, otherwise IDLE with off <= 0.
- stall_in with uop_valid: all state and all outputs hold unchanged.
- seq_stall = uop_valid & ~(uop_last & ~stall_in). IF/ID advances only in the cycle the last micro-op is accepted.
- seq_busy = (state == SEQ).
- Empty mask (LM/SM, mask == 0, IDLE, if_id_valid):
  - lmsm_nop = 1 and uop_valid = 0 for that cycle.
  - seq_stall = 0; the instruction retires as a bubble.
  - State stays IDLE.
- Non-LM/SM instruction: uop_valid, uop_last, seq_stall and lmsm_nop are all 0. The normal decoder drives the pipeline.
- Flush has priority over accept:
  - Next state IDLE, rem <= 0, off <= 0.
  - uop_valid, seq_stall and lmsm_nop are forced to 0 in the flush cycle.
- rst (synchronous): state IDLE, rem 0, off 0, latched fields 0, perf_uop_cnt 0.
  - With if_id_valid = 0, every output is 0 from the cycle after reset is sampled.
  - Reset mid-sequence abandons the sequence; no further micro-ops are issued for it.
- Offsets never wrap: at most 8 micro-ops per instruction, so off ≤ 7.

Optional Feature:
- Macro: LMSM_PERF_EN.
- Defined: perf_uop_cnt increments on every accept and saturates at 16'hFFFF. It is cleared by rst and is not affected by flush.
- Undefined: perf_uop_cnt is tied to 16'h0000 and the counter logic is absent.

Test Plan:
- LM R2, mask 0x05 (instr 0x6405), stall_in = 0:
  - cycle 0: uop_valid = 1, data R0, base R2, off 0, store 0, seq_stall 1.
  - cycle 1: data R2, off 1, uop_last 1, seq_stall 0.
  - cycle 2: state IDLE, uop_valid 0.
- SM R7, mask 0xFF (instr 0x7EFF): 8 consecutive micro-ops, data R0..R7, offsets 0..7, store 1. seq_stall is low only on the 8th; seq_busy is high for cycles 1..7.
- 0x7EFF with stall_in high for 2 cycles during the R3 micro-op: R3/off 3 held for 3 cycles total, then R4..R7 follow; total of 10 cycles.
- Empty mask (instr 0x6200): lmsm_nop = 1 for one cycle, uop_valid 0, seq_stall 0, state stays IDLE.
- flush asserted while issuing R2 of 0xFF, with IF/ID then holding 0x1234: flush cycle has uop_valid 0; next cycle is IDLE with uop_valid 0 and seq_stall 0.
- rst during the R5 micro-op: next cycle all outputs 0, perf_uop_cnt 0. With LMSM_PERF_EN defined, the count before reset equals the micro-ops accepted so far.
